// File: rtl/lfa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfa_pkg
// Description : Shared types and helpers for the line-fill arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lfa_pkg;

    localparam int LFA_AW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lfa_state_t;

    // Ceiling log2, never below 1 so single-entry ranges still get a bit.
    function automatic int lfa_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request at or
//               above ptr, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import lfa_pkg::*;
#(
    parameter int NR = 2,
    parameter int PW = 1
) (
    input  logic [NR-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    logic [2*NR-1:0] w_dbl;
    logic [NR-1:0]   w_rot;
    logic [PW:0]     w_sum;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[NR-1:0];

    always_comb begin
        any   = |w_rot;
        w_sum = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, ptr} + (PW + 1)'(k);
            end
        end
        if (w_sum >= (PW + 1)'(NR)) begin
            w_sum = w_sum - (PW + 1)'(NR);
        end
        idx = w_sum[PW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/line_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_arbiter
// Description : Shares one line-fill memory port among NR cache controllers
//               with round-robin grant and a fill watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module line_fill_arbiter
    import lfa_pkg::*;
#(
    parameter int NR = 2,
    parameter int LW = 512,
    parameter int AW = LFA_AW,
    parameter int TO = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NR-1:0]     rq_start,
    input  logic [NR*AW-1:0]  rq_addr,
    output logic [NR-1:0]     rq_done,
    output logic              rq_err,
    output logic [LW-1:0]     rq_data,
    output logic              busy,
    output logic              m_start,
    output logic [AW-1:0]     m_addr,
    input  logic [LW-1:0]     m_data,
    input  logic              m_done
);

    localparam int              PW         = lfa_clog2(NR);
    localparam int              WW         = lfa_clog2(TO + 1);
    localparam logic [WW-1:0]   c_wd_last  = WW'((TO == 0) ? 0 : TO - 1);
    localparam logic [PW-1:0]   c_last_idx = PW'(NR - 1);

    lfa_state_t     r_state;
    lfa_state_t     w_state_nx;
    logic [NR-1:0]  r_pend;
    logic [AW-1:0]  r_addr [NR];
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  r_gnt;
    logic [WW-1:0]  r_wdog;
    logic           r_err;
    logic           w_any;
    logic [PW-1:0]  w_idx;
    logic [NR-1:0]  w_clr;
    logic           w_timeout;

    rr_pick #(
        .NR (NR),
        .PW (PW)
    ) u_pick (
        .req (r_pend),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    for (genvar i = 0; i < NR; i++) begin : g_req
        assign w_clr[i] = (r_state == RESP) && (r_gnt == PW'(i));
    end

    assign rq_done   = w_clr;
    assign w_timeout = (TO != 0) && (r_wdog == c_wd_last);

    // A new miss in the same cycle as its completion re-arms the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            for (int i = 0; i < NR; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (rq_start[i] && (!r_pend[i] || w_clr[i])) begin
                    r_pend[i] <= 1'b1;
                    r_addr[i] <= rq_addr[i*AW +: AW];
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
            m_addr  <= '0;
            rq_data <= '0;
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_idx;
                        m_addr <= r_addr[w_idx];
                    end
                end
                ISSUE: begin
                    r_wdog <= '0;
                end
                WAIT: begin
                    if (m_done) begin
                        rq_data <= m_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                    end else begin
                        r_wdog  <= r_wdog + WW'(1);
                    end
                end
                RESP: begin
                    r_ptr <= (r_gnt == c_last_idx) ? '0 : r_gnt + PW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nx = r_state;
        m_start    = 1'b0;
        rq_err     = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                m_start    = 1'b1;
                w_state_nx = WAIT;
            end
            WAIT: begin
                if (m_done || w_timeout) begin
                    w_state_nx = RESP;
                end
            end
            RESP: begin
                rq_err     = r_err;
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_line_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_fill_arbiter
// Description : Scoreboard bench for line_fill_arbiter (NR=2, TO=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_arbiter;

    localparam int          NR    = 2;
    localparam int          LW    = 512;
    localparam int          AW    = 32;
    // Makes address 0xABCDEF80 come back as the 0x12345678 line pattern.
    localparam logic [31:0] C_KEY = 32'hB9F9_B9F8;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } iss_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [LW-1:0] data;
        int          cyc;
    } rsp_t;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [NR-1:0]     rq_start = '0;
    logic [NR*AW-1:0]  rq_addr  = '0;
    logic [NR-1:0]     rq_done;
    logic              rq_err;
    logic [LW-1:0]     rq_data;
    logic              busy;
    logic              m_start;
    logic [AW-1:0]     m_addr;
    logic [LW-1:0]     m_data;
    logic              m_done;

    int   cyc   = 0;
    logic rst_d = 1'b1;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];

    // written by the stimulus process only
    bit            mem_en    = 1'b1;
    int            mem_lat   = 4;
    int            inj_a     = -1;
    int            inj_b     = -1;
    int            stall_cnt = 0;
    bit            fin_req   = 1'b0;
    logic [LW-1:0] last_line = '0;

    // written by the memory process only
    int            mem_cnt  = 0;
    logic [31:0]   mem_addr = '0;

    // written by the monitor only
    int            n_cmp      = 0;
    int            n_bad      = 0;
    int            stall_seen = 0;
    bit            fin_ack    = 1'b0;
    logic [LW-1:0] mon_line   = '0;
    iss_t          mon_e;
    rsp_t          mon_r;

    line_fill_arbiter #(
        .NR (NR),
        .LW (LW),
        .AW (AW),
        .TO (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rq_start (rq_start),
        .rq_addr  (rq_addr),
        .rq_done  (rq_done),
        .rq_err   (rq_err),
        .rq_data  (rq_data),
        .busy     (busy),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_done   (m_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc   <= cyc + 1;
    always @(posedge clk) rst_d <= rst;

    function automatic logic [LW-1:0] exp_line(input logic [31:0] a);
        return {16{a ^ C_KEY}};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: answers m_start mem_lat cycles later; inj_* add stray pulses.
    initial begin
        m_done = 1'b0;
        m_data = '0;
        forever begin
            @(posedge clk);
            #2;
            m_done = 1'b0;
            if (rst) mem_cnt = 0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    m_done = 1'b1;
                    m_data = exp_line(mem_addr);
                end
            end
            if (cyc == inj_a || cyc == inj_b) begin
                m_done = 1'b1;
                m_data = ~exp_line(32'h0);
            end
            if (m_start && mem_en && !rst) begin
                mem_cnt  = mem_lat;
                mem_addr = m_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (stall_cnt != stall_seen) begin
            chk("drain_timeout", LW'(stall_cnt), LW'(stall_seen));
            stall_seen = stall_cnt;
        end
        if (rst_d) begin
            mon_line = '0;
            chk("rst_rq_done", LW'(rq_done), '0);
            chk("rst_rq_err",  LW'(rq_err),  '0);
            chk("rst_busy",    LW'(busy),    '0);
            chk("rst_m_start", LW'(m_start), '0);
            chk("rst_m_addr",  LW'(m_addr),  '0);
            chk("rst_rq_data", rq_data,      '0);
        end else begin
            if (m_start) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected_m_start", LW'(m_start), '0);
                end else begin
                    mon_e = exp_iss.pop_front();
                    chk("m_addr", LW'(m_addr), LW'(mon_e.addr));
                    if (mon_e.cyc >= 0) chk("m_start_cycle", LW'(cyc), LW'(mon_e.cyc));
                end
            end
            if (rq_done != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rq_done", LW'(rq_done), '0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    chk("rq_done", LW'(rq_done), LW'(1 << mon_r.idx));
                    chk("rq_err",  LW'(rq_err),  LW'(mon_r.err));
                    chk("rq_data", rq_data,      mon_r.data);
                    if (mon_r.cyc >= 0) chk("rq_done_cycle", LW'(cyc), LW'(mon_r.cyc));
                    mon_line = mon_r.data;
                end
            end else begin
                chk("rq_err_quiet",  LW'(rq_err), '0);
                chk("rq_data_hold",  rq_data,     mon_line);
            end
        end
        if (fin_req && !fin_ack) begin
            chk("leftover_issues",    LW'(exp_iss.size()), '0);
            chk("leftover_responses", LW'(exp_rsp.size()), '0);
            fin_ack = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rq_start = '0;
    endtask

    task automatic issue_req(input int i, input logic [31:0] a);
        rq_start[i]         = 1'b1;
        rq_addr[i*AW +: AW] = a;
    endtask

    task automatic expect_issue(input logic [31:0] a, input int ci);
        iss_t e;
        e.addr = a;
        e.cyc  = ci;
        exp_iss.push_back(e);
    endtask

    task automatic expect_fill(input int i, input logic [31:0] a, input int ci, input int cr);
        rsp_t r;
        expect_issue(a, ci);
        r.idx  = i;
        r.err  = 1'b0;
        r.data = exp_line(a);
        r.cyc  = cr;
        exp_rsp.push_back(r);
        last_line = r.data;
    endtask

    task automatic expect_abort(input int i, input logic [31:0] a, input int ci, input int cr);
        rsp_t r;
        expect_issue(a, ci);
        r.idx  = i;
        r.err  = 1'b1;
        r.data = last_line;
        r.cyc  = cr;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            ok = (exp_iss.size() == 0) && (exp_rsp.size() == 0) && !busy;
        end
        if (!ok) begin
            stall_cnt++;
            exp_iss.delete();
            exp_rsp.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int n0;
        int n1;
        repeat (3) tick();
        rst = 1'b0;

        // Both caches miss together right after reset: 0 first, then 1.
        tick();
        c = cyc;
        issue_req(0, 32'h100);
        issue_req(1, 32'h200);
        expect_fill(0, 32'h100, c + 2, c + 7);
        expect_fill(1, 32'h200, c + 9, c + 14);
        wait_idle(40);

        // Pointer wrapped to 0, so requester 0 leads again.
        tick();
        c = cyc;
        issue_req(0, 32'h140);
        issue_req(1, 32'h240);
        expect_fill(0, 32'h140, c + 2, c + 7);
        expect_fill(1, 32'h240, c + 9, c + 14);
        wait_idle(40);

        // Single fill, rq_done lands 5 cycles after m_start.
        tick();
        c = cyc;
        issue_req(0, 32'hABCD_EF80);
        expect_fill(0, 32'hABCD_EF80, c + 2, c + 7);
        wait_idle(40);

        // Fairness: each requester re-requests in its own rq_done cycle.
        tick();
        issue_req(0, 32'h1000);
        expect_fill(0, 32'h1000, -1, -1);
        repeat (3) tick();
        issue_req(1, 32'h2000);
        expect_fill(1, 32'h2000, -1, -1);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 150 && (n0 < 3 || n1 < 3); k++) begin
            tick();
            if (rq_done[0] && n0 < 3) begin
                n0++;
                issue_req(0, 32'h1000 + 32'(n0) * 32'h40);
                expect_fill(0, 32'h1000 + 32'(n0) * 32'h40, -1, -1);
            end
            if (rq_done[1] && n1 < 3) begin
                n1++;
                issue_req(1, 32'h2000 + 32'(n1) * 32'h40);
                expect_fill(1, 32'h2000 + 32'(n1) * 32'h40, -1, -1);
            end
        end
        wait_idle(40);

        // Watchdog: memory stays silent, abort after 16 WAIT cycles; late m_done ignored.
        mem_en = 1'b0;
        tick();
        c = cyc;
        issue_req(0, 32'h300);
        expect_abort(0, 32'h300, c + 2, c + 19);
        inj_a = c + 21;
        wait_idle(60);
        repeat (4) tick();

        // Stray m_done in IDLE and ISSUE, duplicate request while pending.
        mem_en = 1'b1;
        tick();
        c = cyc;
        issue_req(1, 32'h400);
        expect_fill(1, 32'h400, c + 2, c + 7);
        inj_a = c + 1;
        inj_b = c + 2;
        tick();
        issue_req(1, 32'h480);
        wait_idle(40);

        // Reset in the middle of WAIT: the fill is dropped for good.
        mem_en = 1'b0;
        tick();
        c = cyc;
        issue_req(0, 32'h500);
        expect_issue(32'h500, c + 2);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_line = '0;
        repeat (30) tick();

        // Pending state was cleared: a lone requester 1 goes straight through.
        mem_en = 1'b1;
        tick();
        c = cyc;
        issue_req(1, 32'h600);
        expect_fill(1, 32'h600, c + 2, c + 7);
        wait_idle(40);

        fin_req = 1'b1;
        for (int k = 0; k < 5 && !fin_ack; k++) tick();
        if (!fin_ack) $display("FAIL final_handshake: got %0d expected 1", fin_ack);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
